// File: rtl/button_events.sv
// Turns a debounced push-button level into single-cycle press/release/click/long-press/repeat events.
// `release` and `repeat` are language keywords, so those outputs are named release_pulse and repeat_pulse.
module button_events #(
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic stable,
  output logic press,
  output logic release_pulse,
  output logic click,
  output logic long_press,
  output logic repeat_pulse,
  output logic held
);

  localparam int MAX_CYCLES = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             press_nxt, release_nxt, click_nxt, long_nxt, repeat_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      click         <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      press         <= press_nxt;
      release_pulse <= release_nxt;
      click         <= click_nxt;
      long_press    <= long_nxt;
      repeat_pulse  <= repeat_nxt;
      held          <= (state_nxt != IDLE);
    end
  end

  // cnt is cleared on every state change, so it never passes the larger terminal count.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    case (state)
      IDLE: begin
        if (stable) begin
          state_nxt = PRESSED;
          cnt_nxt   = CNT_ONE;
        end
      end
      PRESSED: begin
        if (!stable) begin
          state_nxt = IDLE;
        end else if (cnt == LONG_LAST) begin
          state_nxt = LONG;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      LONG: begin
        if (!stable) begin
          state_nxt = IDLE;
        end else if (cnt != REPEAT_LAST) begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    click_nxt   = 1'b0;
    long_nxt    = 1'b0;
    repeat_nxt  = 1'b0;
    case (state)
      IDLE:    press_nxt = stable;
      PRESSED: begin
        release_nxt = !stable;
        click_nxt   = !stable;
        long_nxt    = stable && (cnt == LONG_LAST);
      end
      LONG: begin
        release_nxt = !stable;
        repeat_nxt  = stable && (cnt == REPEAT_LAST);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_button_events.sv
// Directed bench for button_events with LONG_CYCLES=8, REPEAT_CYCLES=4.
// Output vector order: {press, release, click, long_press, repeat, held}.
module tb_button_events;

  localparam int LONG_CYCLES   = 8;
  localparam int REPEAT_CYCLES = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stable = 1'b0;
  logic press, release_pulse, click, long_press, repeat_pulse, held;

  int checks   = 0;
  int failures = 0;

  button_events #(
    .LONG_CYCLES  (LONG_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stable       (stable),
    .press        (press),
    .release_pulse(release_pulse),
    .click        (click),
    .long_press   (long_press),
    .repeat_pulse (repeat_pulse),
    .held         (held)
  );

  always #5 clk = ~clk;

  task automatic check_out(input string tag, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Apply one sample of stable, then look at the registered outputs 1 time unit after the edge.
  task automatic sample(input logic s, input logic [5:0] exp, input string tag);
    stable = s;
    @(posedge clk);
    #1;
    check_out(tag, {press, release_pulse, click, long_press, repeat_pulse, held}, exp);
  endtask

  // High samples numbered first..last within one hold; pulses land after sample 1 (press),
  // sample 8 (long_press) and samples 12, 16, 20, ... (repeat).
  task automatic hold(input int first, input int last, input string tag);
    for (int i = first; i <= last; i++) begin
      logic [5:0] e;
      e = 6'b000001;
      if (i == 1) e[5] = 1'b1;
      if (i == LONG_CYCLES) e[2] = 1'b1;
      if (i > LONG_CYCLES && ((i - LONG_CYCLES) % REPEAT_CYCLES) == 0) e[1] = 1'b1;
      sample(1'b1, e, $sformatf("%s_s%0d", tag, i));
    end
  endtask

  task automatic let_go(input logic with_click, input string tag);
    sample(1'b0, {1'b0, 1'b1, with_click, 3'b000}, {tag, "_rel"});
    sample(1'b0, 6'b000000, {tag, "_idle"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held 3 cycles with stable low.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) sample(1'b0, 6'b000000, $sformatf("reset_c%0d", i));
    rst = 1'b0;
    hold(1, 1, "after_reset");
    let_go(1'b1, "after_reset");

    // Short click: 3 samples.
    hold(1, 3, "short");
    let_go(1'b1, "short");

    // Boundary: 7 samples -> click, 8 samples -> long_press, no click.
    hold(1, 7, "hold7");
    let_go(1'b1, "hold7");
    hold(1, 8, "hold8");
    let_go(1'b0, "hold8");

    // Auto-repeat over a 20-sample hold.
    hold(1, 20, "hold20");
    let_go(1'b0, "hold20");

    // Reset at sample 10 with stable still high, then a fresh press.
    hold(1, 9, "midrst");
    rst = 1'b1;
    sample(1'b1, 6'b000000, "midrst_rst");
    rst = 1'b0;
    hold(1, 8, "midrst_new");
    let_go(1'b0, "midrst_new");

    // Single-sample glitch.
    sample(1'b1, 6'b100001, "glitch_press");
    sample(1'b0, 6'b011000, "glitch_rel");
    sample(1'b0, 6'b000000, "glitch_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
